vms_check_sequencer: RTL and testbench
======================================

// Module: vms_check_sequencer
// PURPOSE
// - Transmit side of the vehicle-monitor check-code bus: walks the six pre-start checks and drives each 4-bit code onto the monitor's input.
// - Code order: FuelCheck 0001, UnlockedDoor 0010, SeatBelt 0011, Breaks 0100, BloodPressure 0101, StressLevel 0110.
// - Sits between the sensor cluster (per-check ok bits) and the vehicle-monitor FSM.
// - Waits for the monitor's start flag, then reports done or a fault code.
// PARAMETERS
// - HOLD_CYCLES   8   cycles each code is held on code_out; must be >= 8 to cover the monitor's 7 ns settle.
// - ACK_TIMEOUT   16  cycles to wait for monitor_flag after code 0110 completes its hold.
// - CNT_W         5   timer width; must satisfy 2**CNT_W > max(HOLD_CYCLES, ACK_TIMEOUT).
// PORTS
// - clk           in   1  system clock, rising edge.
// - rst           in   1  synchronous, active-high reset.
// - start_req     in   1  level request; a rising level in IDLE starts a sequence; deassertion aborts or clears.
// - sensor_ok     in   6  bit i = check i+1 passes (bit0 fuel ... bit5 stress).
// - monitor_flag  in   1  monitor reached its start state.
// - code_out      out  4  code driven to the monitor's input; 0000 = NoUser.
// - code_valid    out  1  high while code_out carries a check code (SEND / WAIT_ACK / DONE).
// - busy          out  1  high in SEND and WAIT_ACK.
// - done          out  1  sequence acknowledged by the monitor.
// - fault         out  1  sequence failed.
// - fault_code    out  4  failing check code 1..6; 0111 = ack timeout; 0000 = none.
// BEHAVIOUR
// - All outputs are registered. Reset value of every output is 0; state = IDLE, idx = 0, timer = 0.
// - IDLE: code_out = 0000. On start_req = 1, go to SEND with idx = 0. code_out = 0001 on the cycle after start_req is sampled (1-cycle latency).
// - SEND: code_out = idx+1 and code_valid = 1. The timer counts HOLD_CYCLES.
//   - sensor_ok[idx] is checked every cycle. If it is 0: go to FAULT with fault_code = idx+1; code_out = 0000 next cycle.
//   - Hold expires with idx < 5: idx++; codes are back-to-back with no 0000 gap, because the monitor resets on any unexpected code.
//   - Hold expires with idx = 5: go to WAIT_ACK.
// - WAIT_ACK: keep 0110 on code_out.
//   - monitor_flag = 1: go to DONE.
//   - ACK_TIMEOUT cycles elapse without the flag: go to FAULT with fault_code = 0111.
//   - monitor_flag = 1 on the same cycle as the timeout: DONE wins.
// - DONE: done = 1, code_out holds 0110. When start_req = 0, go to IDLE and clear done.
// - FAULT: fault = 1, code_out = 0000, fault_code sticky. When start_req = 0, go to IDLE and clear fault and fault_code.
// - start_req = 0 during SEND or WAIT_ACK: abort to IDLE next cycle; code_out = 0000; no fault raised.
// - start_req held high through DONE or FAULT never auto-restarts; a new sequence needs a low-then-high.
// - monitor_flag is ignored outside WAIT_ACK.
// - sensor_ok changes after a check's hold has completed are ignored.
// - rst has priority over everything. Reset mid-sequence gives code_out = 0000 next cycle.
// - Timer arithmetic: unsigned CNT_W bits, loaded with N-1 and counted down to 0. It never wraps, because the load value is always < 2**CNT_W.
// STRUCTURE
// - vms_pkg: CODE_NOUSER/FUEL/DOOR/BELT/BRAKE/BP/STRESS/START constants, FAULT_ACK_TO = 4'b0111, and the state encoding.
// - States: IDLE, SEND, WAIT_ACK, DONE, FAULT.
// - Shared with the monitor FSM so both ends use identical codes.
// - One sub-module: vms_hold_timer, a loadable CNT_W down-counter with an expire pulse, used for both the hold and the timeout.
// - Top level: FSM plus idx register plus output registers.
// TESTING
// - Happy path: rst, all sensor_ok = 6'h3F, start_req = 1.
//   -> codes 1..6, each held exactly 8 cycles, no gaps; flag after 3 cycles -> done = 1, code_out = 0110.
// - Sensor fail: sensor_ok[2] = 0.
//   -> SeatBelt appears for 1 cycle, then fault = 1, fault_code = 0011, code_out = 0000; start_req = 0 -> all cleared.
// - Ack timeout: monitor_flag tied low.
//   -> 16 cycles after the 0110 hold ends: fault = 1, fault_code = 0111.
// - Abort: start_req drops during the 0100 hold.
//   -> next cycle IDLE, code_out = 0000, fault = 0, done = 0.
// - Reset mid-sequence: rst pulsed during 0010.
//   -> all outputs 0 next cycle; start_req still high does not restart until low-then-high.
// - Tie: monitor_flag rises on the timeout cycle.
//   -> done = 1, fault = 0.

Source files
------------

// File: rtl/vms_pkg.sv
// Shared code table and state encoding for the vehicle-monitor check bus.
// Both the sequencer and the monitor FSM import this so codes always match.
package vms_pkg;

    localparam logic [3:0] CODE_NOUSER = 4'b0000;
    localparam logic [3:0] CODE_FUEL   = 4'b0001;
    localparam logic [3:0] CODE_DOOR   = 4'b0010;
    localparam logic [3:0] CODE_BELT   = 4'b0011;
    localparam logic [3:0] CODE_BRAKE  = 4'b0100;
    localparam logic [3:0] CODE_BP     = 4'b0101;
    localparam logic [3:0] CODE_STRESS = 4'b0110;
    localparam logic [3:0] CODE_START  = 4'b0111;

    localparam logic [3:0] FAULT_NONE   = 4'b0000;
    localparam logic [3:0] FAULT_ACK_TO = 4'b0111;

    localparam logic [2:0] LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    // Check index 0..5 maps onto codes 0001..0110.
    function automatic logic [3:0] chk_code(input logic [2:0] i);
        return {1'b0, i} + 4'd1;
    endfunction

endpackage

// File: rtl/vms_hold_timer.sv
// Loadable down-counter; expire is high while enabled and the count is 0.
// Ports: clk, rst, load/load_val (reload), en (count), expire.
module vms_hold_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/vms_check_sequencer.sv
// Walks the six pre-start checks onto the monitor bus and reports done/fault.
// Ports: clk, rst, start_req, sensor_ok[5:0], monitor_flag in; code_out,
// code_valid, busy, done, fault, fault_code out (all registered).
module vms_check_sequencer
    import vms_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic [5:0] sensor_ok,
    input  logic       monitor_flag,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] fault_code
);

    state_t           state;
    logic [2:0]       idx;
    logic             start_q;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_exp;
    logic [CNT_W-1:0] tmr_val;
    logic             start_rise;

    assign start_rise = start_req && !start_q;

    // Timer sits preloaded with the hold length in IDLE, and is reloaded
    // on each hold expiry (with the ack window after the last code).
    assign tmr_en   = (state == S_SEND) || (state == S_WAIT_ACK);
    assign tmr_load = (state == S_IDLE) || ((state == S_SEND) && tmr_exp);
    assign tmr_val  = ((state == S_SEND) && (idx == LAST_IDX))
                    ? CNT_W'(ACK_TIMEOUT - 1)
                    : CNT_W'(HOLD_CYCLES - 1);

    vms_hold_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .expire  (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            // Treat a request held across reset as old: needs low-then-high.
            start_q    <= 1'b1;
            code_out   <= CODE_NOUSER;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            start_q <= start_req;
            unique case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        state      <= S_SEND;
                        idx        <= '0;
                        code_out   <= CODE_FUEL;
                        code_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!start_req) begin
                        state      <= S_IDLE;
                        idx        <= '0;
                        code_out   <= CODE_NOUSER;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (!sensor_ok[idx]) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= chk_code(idx);
                        code_out   <= CODE_NOUSER;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (tmr_exp) begin
                        // No gap between codes: monitor resets on 0000.
                        if (idx == LAST_IDX) begin
                            state <= S_WAIT_ACK;
                        end else begin
                            idx      <= idx + 3'd1;
                            code_out <= chk_code(idx + 3'd1);
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (!start_req) begin
                        state      <= S_IDLE;
                        idx        <= '0;
                        code_out   <= CODE_NOUSER;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (monitor_flag) begin
                        // Flag beats a simultaneous timeout.
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (tmr_exp) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_ACK_TO;
                        code_out   <= CODE_NOUSER;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                S_DONE, S_FAULT: begin
                    if (!start_req) begin
                        state      <= S_IDLE;
                        idx        <= '0;
                        code_out   <= CODE_NOUSER;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        fault      <= 1'b0;
                        fault_code <= FAULT_NONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vms_check_sequencer.sv
// Directed bench for vms_check_sequencer: one task per scenario.
// obs packs {code_out, code_valid, busy, done, fault, fault_code}.
module tb_vms_check_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic [5:0] sensor_ok = 6'h3F;
    logic       monitor_flag = 1'b0;
    logic [3:0] code_out;
    logic       code_valid;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] fault_code;
    logic [11:0] obs;
    int checks = 0;
    int failures = 0;

    assign obs = {code_out, code_valid, busy, done, fault, fault_code};

    always #5 clk = ~clk;

    vms_check_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_req   (start_req),
        .sensor_ok   (sensor_ok),
        .monitor_flag(monitor_flag),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Low-then-high request; returns on the first 0001 sample.
    task automatic arm();
        start_req = 1'b0;
        tick();
        start_req = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_req = 1'b0;
        tick(2);
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset obs=%h exp=%h", obs, 12'h000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL idle obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_happy();
        logic [3:0] c;
        sensor_ok = 6'h3F;
        monitor_flag = 1'b0;
        arm();
        for (int i = 1; i <= 6; i++) begin
            c = 4'(i);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs !== {c, 8'hC0}) begin
                    failures++;
                    $display("FAIL happy_code%0d_cyc%0d obs=%h exp=%h",
                             i, k, obs, {c, 8'hC0});
                end
                tick();
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== 12'h6C0) begin
                failures++;
                $display("FAIL happy_wait%0d obs=%h exp=%h", k, obs, 12'h6C0);
            end
            if (k < 2) tick();
        end
        monitor_flag = 1'b1;
        tick();
        checks++;
        if (obs !== 12'h6A0) begin
            failures++;
            $display("FAIL happy_done obs=%h exp=%h", obs, 12'h6A0);
        end
        monitor_flag = 1'b0;
        tick(2);
        checks++;
        if (obs !== 12'h6A0) begin
            failures++;
            $display("FAIL happy_done_hold obs=%h exp=%h", obs, 12'h6A0);
        end
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL happy_clear obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_sensor_fail();
        sensor_ok = 6'b111011;
        arm();
        tick(16);
        checks++;
        if (obs !== 12'h3C0) begin
            failures++;
            $display("FAIL belt_shown obs=%h exp=%h", obs, 12'h3C0);
        end
        tick();
        checks++;
        if (obs !== 12'h013) begin
            failures++;
            $display("FAIL belt_fault obs=%h exp=%h", obs, 12'h013);
        end
        tick(3);
        checks++;
        if (obs !== 12'h013) begin
            failures++;
            $display("FAIL belt_sticky obs=%h exp=%h", obs, 12'h013);
        end
        sensor_ok = 6'h3F;
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL belt_clear obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_ack_timeout();
        sensor_ok = 6'h3F;
        monitor_flag = 1'b0;
        arm();
        tick(48);
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (obs !== 12'h6C0) begin
                failures++;
                $display("FAIL to_wait%0d obs=%h exp=%h", k, obs, 12'h6C0);
            end
        end
        tick();
        checks++;
        if (obs !== 12'h017) begin
            failures++;
            $display("FAIL to_fault obs=%h exp=%h", obs, 12'h017);
        end
        tick(4);
        checks++;
        if (obs !== 12'h017) begin
            failures++;
            $display("FAIL to_no_restart obs=%h exp=%h", obs, 12'h017);
        end
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL to_clear obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_tie();
        sensor_ok = 6'h3F;
        monitor_flag = 1'b0;
        arm();
        tick(48);
        tick(15);
        monitor_flag = 1'b1;
        tick();
        checks++;
        if (obs !== 12'h6A0) begin
            failures++;
            $display("FAIL tie obs=%h exp=%h", obs, 12'h6A0);
        end
        monitor_flag = 1'b0;
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL tie_clear obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_abort();
        sensor_ok = 6'h3F;
        arm();
        monitor_flag = 1'b1;
        tick(3);
        checks++;
        if (obs !== 12'h1C0) begin
            failures++;
            $display("FAIL flag_ignored obs=%h exp=%h", obs, 12'h1C0);
        end
        monitor_flag = 1'b0;
        tick(21);
        checks++;
        if (obs !== 12'h4C0) begin
            failures++;
            $display("FAIL abort_brake obs=%h exp=%h", obs, 12'h4C0);
        end
        sensor_ok = 6'b111000;
        tick(3);
        checks++;
        if (obs !== 12'h4C0) begin
            failures++;
            $display("FAIL old_sensor_ignored obs=%h exp=%h", obs, 12'h4C0);
        end
        sensor_ok = 6'h3F;
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL abort obs=%h exp=%h", obs, 12'h000);
        end
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL abort_idle obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_reset_mid();
        sensor_ok = 6'h3F;
        arm();
        tick(8);
        checks++;
        if (obs !== 12'h2C0) begin
            failures++;
            $display("FAIL rstmid_door obs=%h exp=%h", obs, 12'h2C0);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL rstmid obs=%h exp=%h", obs, 12'h000);
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_no_restart obs=%h exp=%h", obs, 12'h000);
        end
        start_req = 1'b0;
        tick();
        start_req = 1'b1;
        tick();
        checks++;
        if (obs !== 12'h1C0) begin
            failures++;
            $display("FAIL rstmid_restart obs=%h exp=%h", obs, 12'h1C0);
        end
        start_req = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_end obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog obs=%h exp=finished", obs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_happy();
        test_sensor_fail();
        test_ack_timeout();
        test_tie();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
